// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file scoreboard.
//   REG_ADDR_W : width of a register address (rs1/rs2/rd, rf_addressC)
//   NUM_REGS   : number of architectural registers (x0 reads as zero)
//   wb_src_e   : writeback source index (ALU or load unit)
//   arb_pri_e  : round-robin priority state of the writeback arbiter
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LSU = 1'b1
    } arb_pri_e;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter for the writeback port.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (priority returns to PRI_ALU)
//   req      : request vector, indexed by wb_src_e
//   grant    : one-hot (or zero) grant vector, combinational from req
//   priState : current priority holder, visible for debug and checkers
// A lone requester is always granted. With both requesting, the priority
// holder wins and priority passes to the other source at the next edge.
// ----------------------------------------------------------------------------
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output arb_pri_e   priState
);

    logic bothReq;
    assign bothReq = req[WB_ALU] && req[WB_LSU];

    always_comb begin
        grant = 2'b00;
        if (bothReq) begin
            if (priState == PRI_ALU) grant[WB_ALU] = 1'b1;
            else                     grant[WB_LSU] = 1'b1;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            priState <= PRI_ALU;
        end else if (bothReq) begin
            priState <= (priState == PRI_ALU) ? PRI_LSU : PRI_ALU;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Issue-side hazard scoreboard plus writeback arbitration for a register file
// with a single registered write port.
//
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   issue_valid / issue_ready    : decode issue handshake (ready is comb)
//   issue_rs1/rs2/rd             : source / destination addresses
//   issue_uses_rs2               : 0 when operand B is an immediate
//   issue_writes_rd              : instruction writes rd
//   alu_wb_* / lsu_wb_*          : writeback handshakes + payload
//   rf_write_en/addressC/writeBack : registered register-file write port
//   busy_vec                     : pending-write bit per register
//   wb_err                       : sticky, writeback to a non-busy register
//   arbPriDbg                    : writeback arbiter priority state
//
// Handshake: a transfer happens at a rising edge where valid && ready are
// both 1. Ready may depend combinationally on valid and on current state;
// valid must not depend on ready.
//
// Build option: define SCOREBOARD_BYPASS_EN to treat the register being
// written this cycle (rf_write_en=1) as free, so a dependent instruction
// issues one cycle earlier. Without it, hazards use busy_vec only.
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::REG_ADDR_W;
    import regfile_pkg::arb_pri_e;
    import regfile_pkg::WB_ALU;
    import regfile_pkg::WB_LSU;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int NUM_REGS       = regfile_pkg::NUM_REGS
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [REG_ADDR_W-1:0]     issue_rs1,
    input  logic [REG_ADDR_W-1:0]     issue_rs2,
    input  logic [REG_ADDR_W-1:0]     issue_rd,
    input  logic                      issue_uses_rs2,
    input  logic                      issue_writes_rd,

    input  logic                      alu_wb_valid,
    output logic                      alu_wb_ready,
    input  logic [REG_ADDR_W-1:0]     alu_wb_rd,
    input  logic [BUS_DATA_WIDTH-1:0] alu_wb_data,

    input  logic                      lsu_wb_valid,
    output logic                      lsu_wb_ready,
    input  logic [REG_ADDR_W-1:0]     lsu_wb_rd,
    input  logic [BUS_DATA_WIDTH-1:0] lsu_wb_data,

    output logic                      rf_write_en,
    output logic [REG_ADDR_W-1:0]     rf_addressC,
    output logic [BUS_DATA_WIDTH-1:0] rf_writeBack,

    output logic [NUM_REGS-1:0]       busy_vec,
    output logic                      wb_err,
    output arb_pri_e                  arbPriDbg
);

    logic [NUM_REGS-1:0]       busy;
    logic [NUM_REGS-1:0]       busyNext;
    logic [NUM_REGS-1:0]       hazBusy;
    logic [1:0]                wbReq;
    logic [1:0]                wbGrant;
    logic                      wbAccept;
    logic                      wbWrite;
    logic [REG_ADDR_W-1:0]     wbRd;
    logic [BUS_DATA_WIDTH-1:0] wbData;
    logic                      issueSet;

    // ---------------- writeback arbitration ----------------
    assign wbReq[WB_ALU] = alu_wb_valid;
    assign wbReq[WB_LSU] = lsu_wb_valid;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (wbReq),
        .grant    (wbGrant),
        .priState (arbPriDbg)
    );

    // Ready is forced low during reset so nothing can be accepted then.
    assign alu_wb_ready = reset_n && wbGrant[WB_ALU];
    assign lsu_wb_ready = reset_n && wbGrant[WB_LSU];

    assign wbAccept = (alu_wb_valid && alu_wb_ready) || (lsu_wb_valid && lsu_wb_ready);
    assign wbRd     = lsu_wb_ready ? lsu_wb_rd   : alu_wb_rd;
    assign wbData   = lsu_wb_ready ? lsu_wb_data : alu_wb_data;
    // x0 writebacks are consumed but never reach the register file.
    assign wbWrite  = wbAccept && (wbRd != '0);

    // ---------------- issue hazard check ----------------
    always_comb begin
        hazBusy = busy;
`ifdef SCOREBOARD_BYPASS_EN
        if (rf_write_en) hazBusy[rf_addressC] = 1'b0;
`endif
    end

    assign issue_ready = !hazBusy[issue_rs1]
                      && !(issue_uses_rs2  && hazBusy[issue_rs2])
                      && !(issue_writes_rd && hazBusy[issue_rd]);

    assign issueSet = issue_valid && issue_ready && issue_writes_rd && (issue_rd != '0);

    // Clear from the committing write first, then set from issue, so a
    // same-edge set/clear on one register leaves it busy.
    always_comb begin
        busyNext = busy;
        if (rf_write_en) busyNext[rf_addressC] = 1'b0;
        if (issueSet)    busyNext[issue_rd]    = 1'b1;
        busyNext[0] = 1'b0;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= '0;
            rf_write_en  <= 1'b0;
            rf_addressC  <= '0;
            rf_writeBack <= '0;
            wb_err       <= 1'b0;
        end else begin
            busy        <= busyNext;
            rf_write_en <= wbWrite;
            if (wbWrite) begin
                rf_addressC  <= wbRd;
                rf_writeBack <= wbData;
            end
            // A write nobody was waiting for indicates a protocol slip.
            if (wbWrite && !busy[wbRd]) wb_err <= 1'b1;
        end
    end

    assign busy_vec = busy;

endmodule
